nes_poll_scheduler: RTL and testbench
=====================================

// Module: nes_poll_scheduler
// PURPOSE
//  Sequences serial readout of two NES pads sharing one latch/pulse pair. Scans run
//  periodically or on request. Each pad's data line is shifted in; results are published
//  as active-high button bytes with a one-cycle valid strobe.
//  Sits between the NES connector pins and the LED/consumer logic.
// PARAMETERS
//  LATCH_CYCLES   600      latch high time in clocks (12 us @ 50 MHz)
//  HALF_BIT       300      pulse high time and pulse low time in clocks (6 us @ 50 MHz)
//  POLL_INTERVAL  833333   clocks from one scan start to the next (60 Hz @ 50 MHz);
//                          must exceed LATCH_CYCLES+15*HALF_BIT+1
// PORTS
//  clock      in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous, active-low reset
//  enable     in   1  1 = periodic scanning allowed; 0 = no new scan starts
//  poll_now   in   1  one-cycle request to start a scan immediately (when idle and enabled)
//  data0      in   1  pad 0 serial data, active-low (0 = pressed)
//  data1      in   1  pad 1 serial data, active-low
//  latch      out  1  shared pad latch
//  pulse      out  1  shared pad clock
//  buttons0   out  8  pad 0 state, 1 = pressed; bit0 A,1 B,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right
//  buttons1   out  8  pad 1 state, same bit order
//  valid      out  1  one-cycle strobe: buttons0/1 updated this cycle
//  busy       out  1  1 while a scan is in progress (LATCH..DONE)
//  pressed0   out  8  pad 0 newly-pressed bits (see CONFIGURATION)
//  pressed1   out  8  pad 1 newly-pressed bits
// BEHAVIOUR
//  Reset (reset==0 at an edge, including mid-scan):
//   - FSM -> IDLE; all outputs 0; interval counter 0; shift registers 0.
//  FSM states: IDLE, LATCH, SETTLE, PULSE_HI, PULSE_LO, DONE.
//   IDLE:
//    - Interval counter increments each cycle.
//    - Start condition: enable & (poll_now | counter==POLL_INTERVAL-1).
//    - On start: -> LATCH, counter cleared. Interval is measured start-to-start.
//   LATCH:
//    - latch=1 for LATCH_CYCLES cycles, then -> SETTLE.
//   SETTLE:
//    - latch=0, pulse=0 for HALF_BIT cycles.
//    - Last cycle samples bit index 0 (A) from data0/data1.
//    - Then -> PULSE_HI.
//   PULSE_HI:
//    - pulse=1 for HALF_BIT cycles, then -> PULSE_LO.
//   PULSE_LO:
//    - pulse=0 for HALF_BIT cycles.
//    - Last cycle samples the next bit index (1..7).
//    - After bit 7 -> DONE; otherwise -> PULSE_HI.
//   Scan shape: exactly 7 pulse rising edges per scan. Samples are stored inverted (~data).
//   DONE (one cycle):
//    - buttons0/1 <= sampled bytes; valid=1.
//    - -> IDLE. busy drops the same edge.
//  Latency: LATCH_CYCLES + 15*HALF_BIT + 1 clocks from start to valid.
//  Boundary conditions:
//   - poll_now while busy: ignored, not queued.
//   - poll_now coincident with interval expiry: one scan only.
//   - enable falling mid-scan: current scan completes normally; no new scan starts.
//   - enable=0 in IDLE: interval counter holds at 0.
//   - buttons0/1 hold their value between valid strobes.
// CONFIGURATION
//  NES_PRESS_EDGE_EN defined:
//   - At DONE, pressed0/1 = new & ~previous buttons; written with valid.
//   - pressed0/1 clear to 0 on the next cycle.
//  NES_PRESS_EDGE_EN undefined:
//   - pressed0/1 tied to 8'h00; no history logic.
// TESTING  (bench params: LATCH_CYCLES=4, HALF_BIT=2, POLL_INTERVAL=100; pad serial models)
//  1. Single scan: poll_now=1 for 1 cycle, pad0 holds A+Start, pad1 idle
//     -> latch high 4 cycles; 7 pulse rising edges; valid at start+35;
//        buttons0=8'h09, buttons1=8'h00.
//  2. enable=1, no poll_now -> scan starts every 100 cycles; valid strobes 100 cycles apart.
//  3. Extra poll_now pulses during a busy scan -> still 7 pulses; exactly one valid.
//  4. Drive reset low for 2 cycles mid-PULSE_HI
//     -> next edge latch=pulse=valid=busy=0, buttons=0; a fresh poll_now completes normally.
//  5. enable dropped during LATCH -> scan finishes with valid=1; no further latch for 300 cycles.
//  6. Scan with A held, then scan with A+B held
//     -> with NES_PRESS_EDGE_EN: pressed0=8'h02 for one cycle at second valid.
//     -> without NES_PRESS_EDGE_EN: pressed0 stays 8'h00.

Source files
------------

// File: rtl/nes_poll_scheduler.sv
// Serial readout scheduler for two NES pads sharing one latch/pulse pair.
// Optional macro NES_PRESS_EDGE_EN adds newly-pressed strobes on pressed0/pressed1.
module nes_poll_scheduler #(
  parameter int LATCH_CYCLES  = 600,
  parameter int HALF_BIT      = 300,
  parameter int POLL_INTERVAL = 833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_now,
  input  logic       data0,
  input  logic       data1,
  output logic       latch,
  output logic       pulse,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       valid,
  output logic       busy,
  output logic [7:0] pressed0,
  output logic [7:0] pressed1
);

  typedef enum logic [2:0] {
    IDLE, LATCH, SETTLE, PULSE_HI, PULSE_LO, DONE
  } state_t;

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int IW        = $clog2(POLL_INTERVAL + 1);

  state_t          state, state_n;
  logic [PW-1:0]   phase;
  logic [IW-1:0]   ivl;
  logic [2:0]      bit_idx;
  logic [7:0]      sh0, sh1;
  logic            start, last_latch, last_half, sample;

  assign last_latch = (phase == PW'(LATCH_CYCLES - 1));
  assign last_half  = (phase == PW'(HALF_BIT - 1));
  assign start      = (state == IDLE) && enable &&
                      (poll_now || (ivl == IW'(POLL_INTERVAL - 1)));
  // Bit 0 is taken at the end of SETTLE, bits 1..7 at the end of each PULSE_LO.
  assign sample     = ((state == SETTLE) || (state == PULSE_LO)) && last_half;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start)      state_n = LATCH;
      LATCH:    if (last_latch) state_n = SETTLE;
      SETTLE:   if (last_half)  state_n = PULSE_HI;
      PULSE_HI: if (last_half)  state_n = PULSE_LO;
      PULSE_LO: if (last_half)  state_n = (bit_idx == 3'd7) ? DONE : PULSE_HI;
      DONE:                     state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      phase    <= '0;
      ivl      <= '0;
      bit_idx  <= '0;
      sh0      <= '0;
      sh1      <= '0;
      buttons0 <= '0;
      buttons1 <= '0;
      valid    <= 1'b0;
    end else begin
      state <= state_n;
      phase <= ((state_n != state) || (state == IDLE)) ? '0 : phase + PW'(1);

      // Start-to-start interval; parked at 0 whenever scanning is disabled.
      if (!enable || start)
        ivl <= '0;
      else if (ivl != IW'(POLL_INTERVAL - 1))
        ivl <= ivl + IW'(1);

      if (start)
        bit_idx <= '0;
      else if (sample)
        bit_idx <= bit_idx + 3'd1;

      // LSB-first shift: after eight samples bit 0 (A) sits in position 0.
      if (sample) begin
        sh0 <= {~data0, sh0[7:1]};
        sh1 <= {~data1, sh1[7:1]};
      end

      valid <= (state == DONE);
      if (state == DONE) begin
        buttons0 <= sh0;
        buttons1 <= sh1;
      end
    end
  end

  assign latch = (state == LATCH);
  assign pulse = (state == PULSE_HI);
  assign busy  = (state != IDLE);

`ifdef NES_PRESS_EDGE_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      pressed0 <= '0;
      pressed1 <= '0;
    end else if (state == DONE) begin
      pressed0 <= sh0 & ~buttons0;
      pressed1 <= sh1 & ~buttons1;
    end else begin
      pressed0 <= '0;
      pressed1 <= '0;
    end
  end
`else
  assign pressed0 = 8'h00;
  assign pressed1 = 8'h00;
`endif

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Scoreboard bench for nes_poll_scheduler with behavioural serial pad models.
module tb_nes_poll_scheduler;

  localparam int LC = 4;
  localparam int HB = 2;
  localparam int PI = 100;
  localparam int LAT = LC + 15 * HB + 1;

  logic       clock = 1'b0;
  logic       reset, enable, poll_now;
  logic       data0, data1;
  logic       latch, pulse, valid, busy;
  logic [7:0] buttons0, buttons1, pressed0, pressed1;
  logic [7:0] pad0, pad1;

  nes_poll_scheduler #(.LATCH_CYCLES(LC), .HALF_BIT(HB), .POLL_INTERVAL(PI)) dut (
    .clock(clock), .reset(reset), .enable(enable), .poll_now(poll_now),
    .data0(data0), .data1(data1), .latch(latch), .pulse(pulse),
    .buttons0(buttons0), .buttons1(buttons1), .valid(valid), .busy(busy),
    .pressed0(pressed0), .pressed1(pressed1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pad model: latch reloads to bit 0, each pulse rising edge advances one bit.
  int idx = 8;
  always @(posedge latch or posedge pulse) begin
    if (latch) idx = 0;
    else       idx = idx + 1;
  end
  assign data0 = (idx < 8) ? ~pad0[idx[2:0]] : 1'b1;
  assign data1 = (idx < 8) ? ~pad1[idx[2:0]] : 1'b1;

  typedef struct {
    logic [7:0] b0, b1, p0, p1;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int scans    = 0;
  logic [7:0] prev0 = 8'h00, prev1 = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] b0, input logic [7:0] b1, input int c);
    exp_t e;
    e.b0 = b0;
    e.b1 = b1;
`ifdef NES_PRESS_EDGE_EN
    e.p0 = b0 & ~prev0;
    e.p1 = b1 & ~prev1;
`else
    e.p0 = 8'h00;
    e.p1 = 8'h00;
`endif
    e.cyc = c;
    prev0 = b0;
    prev1 = b1;
    sb.push_back(e);
  endtask

  task automatic start_poll(input logic [7:0] b0, input logic [7:0] b1, input bit expect_it);
    pad0 = b0;
    pad1 = b1;
    if (expect_it) push_exp(b0, b1, cyc + LAT + 1);
    poll_now = 1'b1;
    @(negedge clock);
    poll_now = 1'b0;
  endtask

  task automatic pulse_poll_at(input int c);
    while (cyc < c) @(negedge clock);
    poll_now = 1'b1;
    @(negedge clock);
    poll_now = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      check("scan_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor, sampled on the falling edge.
  logic latch_q = 1'b0, pulse_q = 1'b0, valid_q = 1'b0;
  int   lat_cnt = 0, pul_cnt = 0;
  always @(negedge clock) begin
    if (latch && !latch_q) begin
      lat_cnt = 0;
      pul_cnt = 0;
      scans++;
    end
    if (latch) lat_cnt++;
    if (pulse && !pulse_q) pul_cnt++;
    if (valid_q) begin
      check("pressed0_clear", pressed0, 8'h00);
      check("pressed1_clear", pressed1, 8'h00);
    end
    if (valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("buttons0", buttons0, e.b0);
        check("buttons1", buttons1, e.b1);
        check("pressed0", pressed0, e.p0);
        check("pressed1", pressed1, e.p1);
        check("valid_cycle", cyc, e.cyc);
        check("latch_len", lat_cnt, LC);
        check("pulse_edges", pul_cnt, 7);
        check("busy_at_valid", busy, 1'b0);
      end
    end
    latch_q = latch;
    pulse_q = pulse;
    valid_q = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    reset = 1'b0; enable = 1'b0; poll_now = 1'b0; pad0 = 8'h00; pad1 = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_latch", latch, 1'b0);
    check("rst_pulse", pulse, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_buttons0", buttons0, 8'h00);
    check("rst_pressed0", pressed0, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single requested scan: A+Start on pad 0.
    enable = 1'b1;
    start_poll(8'h09, 8'h00, 1'b1);
    repeat (8) @(negedge clock);
    check("busy_mid_scan", busy, 1'b1);
    wait_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("buttons0_hold", buttons0, 8'h09);

    // Periodic scans; second expiry coincides with a poll_now request.
    pad0 = 8'h81;
    pad1 = 8'h42;
    n = cyc;
    enable = 1'b1;
    push_exp(8'h81, 8'h42, n + PI + LAT);
    push_exp(8'h81, 8'h42, n + 2 * PI + LAT);
    pulse_poll_at(n + 2 * PI - 1);
    wait_done();
    enable = 1'b0;

    // Extra requests while busy are dropped.
    repeat (2) @(negedge clock);
    enable = 1'b1;
    n = cyc;
    s0 = scans;
    start_poll(8'h10, 8'h20, 1'b1);
    pulse_poll_at(n + 5);
    pulse_poll_at(n + 20);
    pulse_poll_at(n + LAT - 1);
    wait_done();
    enable = 1'b0;
    repeat (40) @(negedge clock);
    check("one_scan_busy_polls", scans - s0, 1);

    // Enable dropped during LATCH: scan completes, nothing new starts.
    enable = 1'b1;
    s0 = scans;
    start_poll(8'hFF, 8'h01, 1'b1);
    enable = 1'b0;
    wait_done();
    pulse_poll_at(cyc + 10);
    repeat (300) @(negedge clock);
    check("no_rescan_disabled", scans - s0, 1);

    // Reset in PULSE_HI.
    enable = 1'b1;
    n = cyc;
    start_poll(8'h5A, 8'hA5, 1'b0);
    while (cyc < n + LC + HB + 1) @(negedge clock);
    check("pulse_hi_before_rst", pulse, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_latch", latch, 1'b0);
    check("mid_rst_pulse", pulse, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_buttons0", buttons0, 8'h00);
    check("mid_rst_buttons1", buttons1, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    prev0 = 8'h00;
    prev1 = 8'h00;
    repeat (2) @(negedge clock);
    start_poll(8'h40, 8'h80, 1'b1);
    wait_done();
    enable = 1'b0;

    // A held, then A+B held.
    repeat (2) @(negedge clock);
    enable = 1'b1;
    start_poll(8'h01, 8'h00, 1'b1);
    wait_done();
    start_poll(8'h03, 8'h00, 1'b1);
    wait_done();
    enable = 1'b0;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
